// File: rtl/fetch_unit_pkg.sv
// Shared RV32I constants for the front end: opcodes, the canonical NOP and the default reset PC.
package fetch_unit_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR    = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory req/gnt/rvalid bus between the fetch stage and instruction memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit_buffer.sv
// One-entry hold register that parks an accepted response while the IF/ID register is stalled.
module fetch_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic [31:0] pc_in,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] pc
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem handshake and the IF/ID register.
// state | meaning
// REQ   | request pc when buffer empty and not stalled
// WAIT  | one request in flight, back-to-back request on rvalid
// FLUSH | wrong-path request in flight, its data is dropped
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic                id_valid,
  output logic [31:0]         id_instruction,
  output logic [31:0]         id_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic        buf_valid, buf_load, buf_clear;
  logic [31:0] buf_data, buf_pc;
  logic        can_req, accept, req;
  logic [31:0] target;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_req_d = pc_req_q;
    req      = 1'b0;
    accept   = 1'b0;
    target   = word_align(redirect_pc);
    can_req  = rst_n && !stall && !buf_valid;
    case (state_q)
      S_REQ: begin
        req = can_req;
        if (redirect) begin
          pc_d = target;
          if (req && imem.imem_gnt) state_d = S_FLUSH;
        end else if (req && imem.imem_gnt) begin
          pc_req_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem.imem_rvalid ? S_REQ : S_FLUSH;
        end else if (imem.imem_rvalid) begin
          accept = 1'b1;
          req    = can_req;
          if (req && imem.imem_gnt) begin
            pc_req_d = pc_q;
            pc_d     = pc_q + 32'd4;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_FLUSH: begin
        if (redirect) pc_d = target;
        // the stale response retires the flush even if a new redirect lands with it
        if (imem.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    if (redirect) begin
      id_valid_d = 1'b0;
      buf_clear  = 1'b1;
    end else if (stall) begin
      buf_load = accept;
    end else if (buf_valid) begin
      id_valid_d = 1'b1;
      id_instr_d = buf_data;
      id_pc_d    = buf_pc;
      buf_clear  = 1'b1;
    end else if (accept) begin
      id_valid_d = 1'b1;
      id_instr_d = imem.imem_rdata;
      id_pc_d    = pc_req_q;
    end else begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pc_req_q   <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_req_q   <= pc_req_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  fetch_buffer u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load),
    .clear   (buf_clear),
    .data_in (imem.imem_rdata),
    .pc_in   (pc_req_q),
    .valid   (buf_valid),
    .data    (buf_data),
    .pc      (buf_pc)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign id_valid       = id_valid_q;
  assign id_instruction = id_valid_q ? id_instr_q : NOP_INSTR;
  assign id_pc          = id_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed pipeline scenarios then random latency/stall/redirect traffic.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instruction, id_pc;
  logic        id_valid2;
  logic [31:0] id_instruction2, id_pc2;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] model_pc = RESET_PC_DEF;
  bit          pend = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          fixed_lat = 1;
  bit          rnd_gnt = 1'b0;
  bit          gnt_en = 1'b1;
  logic        s_req = 1'b0;
  logic [31:0] s_addr = '0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (1'b0),
    .redirect       (1'b0),
    .redirect_pc    (32'h0),
    .imem           (bus2),
    .id_valid       (id_valid2),
    .id_instruction (id_instruction2),
    .id_pc          (id_pc2)
  );

  // always-granting 1-cycle memory for the wrap instance
  logic        rvalid2_q;
  logic [31:0] addr2_log[$];
  always @(posedge clk) rvalid2_q <= rst_n && bus2.imem_req;
  assign bus2.imem_gnt    = 1'b1;
  assign bus2.imem_rvalid = rvalid2_q;
  assign bus2.imem_rdata  = NOP_INSTR;
  always @(negedge clk)
    if (rst_n && bus2.imem_req && addr2_log.size() < 4) addr2_log.push_back(bus2.imem_addr);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, answer the bus, and advance the reference model.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    if (pend && lat_cnt == 1) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    @(negedge clk);
    s_req  = bus.imem_req;
    s_addr = bus.imem_addr;
    bus.imem_gnt = s_req && gnt_en && (!rnd_gnt || $urandom_range(0, 3) != 0);
    @(posedge clk);
    if (!rst_n) begin
      pend = 1'b0;
      exp_q.delete();
      model_pc = RESET_PC_DEF;
    end else begin
      if (bus.imem_rvalid) pend = 1'b0;
      else if (pend) lat_cnt--;
      if (s_req && bus.imem_gnt) begin
        check32("fetch_addr", s_addr, model_pc);
        exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
        model_pc  = model_pc + 32'd4;
        pend      = 1'b1;
        pend_addr = s_addr;
        lat_cnt   = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
      end
      if (r) begin
        exp_q.delete();
        model_pc = rpc & 32'hFFFF_FFFC;
      end
    end
    #1;
  endtask

  initial begin : monitor
    logic prev_stall;
    exp_t e;
    prev_stall = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && id_valid && !prev_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL id_unexpected actual_pc=%08h required=none", id_pc);
        end else begin
          e = exp_q.pop_front();
          check32("id_pc", id_pc, e.pc);
          check32("id_instr", id_instruction, e.instr);
        end
      end
      if (rst_n && !id_valid) check32("id_nop", id_instruction, NOP_INSTR);
      prev_stall = stall || !rst_n;
    end
  end

  initial begin
    logic        rs, rr;
    logic [31:0] rp;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    @(posedge clk);
    #1;

    repeat (2) step(1'b0, 1'b0, 32'h0);
    check32("rst_req", {31'b0, s_req}, 32'h0);
    check32("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check32("rst_id_instr", id_instruction, NOP_INSTR);
    check32("rst_id_pc", id_pc, RESET_PC_DEF);

    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    check32("first_req", {31'b0, s_req}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    check32("lat_id_valid", {31'b0, id_valid}, 32'h1);
    check32("lat_id_pc", id_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check32("thru_id_valid", {31'b0, id_valid}, 32'h1);
    check32("thru_id_pc", id_pc, 32'h4);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check32("stall_req", {31'b0, s_req}, 32'h0);
      check32("stall_id_pc", id_pc, 32'h4);
      check32("stall_id_valid", {31'b0, id_valid}, 32'h1);
    end
    step(1'b0, 1'b0, 32'h0);
    check32("unstall_id_pc", id_pc, 32'h8);
    step(1'b0, 1'b0, 32'h0);
    fixed_lat = 2;
    step(1'b0, 1'b0, 32'h0);
    check32("after_id_pc", id_pc, 32'hC);

    step(1'b0, 1'b1, 32'h100);
    check32("redir_id_valid", {31'b0, id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check32("flush_req", {31'b0, s_req}, 32'h0);
    check32("flush_id_valid", {31'b0, id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check32("target_req", {31'b0, s_req}, 32'h1);
    check32("target_addr", s_addr, 32'h100);
    step(1'b0, 1'b0, 32'h0);
    check32("wait_id_valid", {31'b0, id_valid}, 32'h0);
    fixed_lat = 1;
    step(1'b0, 1'b0, 32'h0);
    check32("target_id_valid", {31'b0, id_valid}, 32'h1);
    check32("target_id_pc", id_pc, 32'h100);

    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h103);
    check32("redir_stall_valid", {31'b0, id_valid}, 32'h0);
    check32("redir_stall_instr", id_instruction, 32'h0000_0013);
    step(1'b0, 1'b0, 32'h0);
    check32("align_addr", s_addr, 32'h100);

    rnd_gnt   = 1'b1;
    fixed_lat = 0;
    for (int i = 0; i < 800; i++) begin
      rs = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 29) == 0);
      rp = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(rs, rr, rp);
    end

    gnt_en = 1'b0;
    repeat (10) step(1'b0, 1'b0, 32'h0);
    check32("drain_queue", 32'(exp_q.size()), 32'h0);

    if (addr2_log.size() < 2) begin
      checks++;
      failures++;
      $display("FAIL wrap_fetch_count actual=%0d required=2", addr2_log.size());
    end else begin
      check32("wrap_first", addr2_log[0], 32'hFFFF_FFFC);
      check32("wrap_second", addr2_log[1], 32'h0000_0000);
    end
    check32("wrap_id_valid", {31'b0, id_valid2}, 32'h1);
    check32("wrap_id_instr", id_instruction2, NOP_INSTR);
    check32("wrap_id_pc_align", {30'b0, id_pc2[1:0]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I pipeline: owns the program counter, fetches from instruction memory over a req/gnt/rvalid handshake, and drives the IF/ID register that feeds the instruction decoder/control block. It honours `stall` from the hazard logic, discards wrong-path fetches on a branch/jump `redirect`, and emits a canonical NOP when no valid instruction is present, so the decoder never flags `ill_instr` on a bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013 (addi x0,x0,0), value driven on `id_instruction` when `id_valid`=0

- `clk` input 1: single clock; all state changes on the rising edge
- `rst_n` input 1: synchronous, active-low reset
- `stall` input 1: hold the IF/ID register and suppress new requests
- `redirect` input 1: branch taken / jump, PC must change
- `redirect_pc` input 32: target; bits [1:0] are forced to 0 internally
- `imem_req` output 1: fetch request
- `imem_addr` output 32: fetch address, valid while `imem_req`=1
- `imem_gnt` input 1: request accepted this cycle
- `imem_rvalid` input 1: read data valid, earliest 1 cycle after `imem_gnt`
- `imem_rdata` input 32: instruction word
- `id_valid` output 1: IF/ID holds a real instruction
- `id_instruction` output 32: to the decoder
- `id_pc` output 32: PC of `id_instruction`

## Operation
- At most one outstanding memory request; `pc` is the next address to fetch, `pc_req` is the address in flight.
- FSM states:
  - REQ: `imem_req`=1 with `imem_addr`=`pc`, provided the hold buffer is empty and `stall`=0. `imem_gnt` -> WAIT, `pc_req`<=`pc`, `pc`<=`pc`+4. `redirect` without gnt -> `pc`<=`redirect_pc`, stay REQ. `redirect` with gnt -> FLUSH.
  - WAIT: on `imem_rvalid` with no `redirect`, the response is accepted. Same cycle, if `stall`=0 and the buffer is empty, `imem_req`=1 at `pc` (back-to-back): gnt -> stay WAIT, otherwise -> REQ. `redirect` with no rvalid -> FLUSH. `redirect` with rvalid -> data discarded, -> REQ. Either redirect case sets `pc`<=`redirect_pc`.
  - FLUSH: `imem_req`=0; wait for `imem_rvalid`, discard the data, -> REQ. A further `redirect` in FLUSH overwrites `pc` and stays in FLUSH.
- Accepted response goes to IF/ID if `stall`=0. If `stall`=1 it goes to the one-entry hold buffer (data + `pc_req`).
- IF/ID update priority per cycle:
  1. reset
  2. `redirect`: `id_valid`<=0, buffer cleared
  3. `stall`: hold
  4. buffer valid: load from buffer, clear buffer
  5. accepted response: load it
  6. otherwise `id_valid`<=0
- Whenever `id_valid`=0, `id_instruction`=`NOP_INSTR`.
- `redirect` has priority over `stall`.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset (`rst_n`=0 at an edge): state REQ, `pc`=`RESET_PC`, buffer empty, `id_valid`=0, `id_instruction`=`NOP_INSTR`, `id_pc`=`RESET_PC`. `imem_req`=0 while `rst_n`=0; first request in the first cycle with `rst_n`=1.
- Reset mid-transaction: any outstanding response is not tracked. The memory model is reset alongside this block.
- Latency: gnt in cycle N, rvalid in N+1, `id_valid`=1 from N+2.
- Throughput: one instruction per cycle with a 1-cycle memory and no stall.
- Redirect in cycle N: first request to the target no earlier than N+1 (REQ) or one cycle after the flushed rvalid (FLUSH). `id_valid`=0 from N+1 until the target instruction arrives.
- Buffer full implies `imem_req`=0, so rvalid can never arrive while the buffer is full.
- `imem_req` in WAIT depends combinationally on `imem_rvalid`, `stall`, `redirect`; no combinational path from `imem_rdata` to outputs.

## Structure
- `NOP_INSTR` value and `RESET_PC` default live in the shared constants header next to the opcode definitions; FSM state encodings stay local.
- Sub-module `fetch_buffer`: one-entry hold register with valid, data, pc, load/clear.

## Test plan
- Reset, 1-cycle memory, no stall -> requests 0x0,0x4,0x8 on consecutive cycles; `id_pc` 0x0,0x4,0x8 starting cycle 2 after reset release, `id_valid` held at 1.
- `stall` asserted the cycle 0x8 arrives, held 3 cycles -> 0x4 held in IF/ID, 0x8 buffered, `imem_req`=0 throughout; after release `id_pc`=0x8, then 0xC.
- `redirect`=1, `redirect_pc`=0x100 while WAIT for 0x10 -> FLUSH; 0x10 data discarded; next request 0x100; `id_valid`=0 until `id_pc`=0x100.
- `redirect` and `stall` in the same cycle with a buffered entry -> buffer and IF/ID cleared, `id_instruction`=0x0000_0013.
- `redirect_pc`=0x103 -> fetch at 0x100; `RESET_PC`=0xFFFF_FFFC -> second fetch at 0x0.
- Random 1–4 cycle rvalid latency vs. reference PC model -> in-order `id_pc`, no dropped or duplicated instruction.
